// File: rtl/dcache_arbiter_pkg.sv
// Shared definitions for the data-cache arbiter: FSM encodings and default sizing.
package dcache_arbiter_pkg;

    localparam int WIDTH_DEF   = 12;
    localparam int ROB_TAGW    = 6;
    localparam int SQDEPTH_DEF = 4;
    localparam int STARVE_DEF  = 3;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Pointer width for a queue of the given depth; a depth of one still needs a bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dcache_arbiter_store_fifo.sv
// Committed-store queue: circular FIFO with a parallel word-address match against
// every valid entry, used to hold back loads that would read stale data.
module store_fifo
    import dcache_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SQDEPTH = SQDEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_addr,
    input  logic [31:0]      enq_data,
    input  logic             deq,
    input  logic [WIDTH-3:0] match_word,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_addr,
    output logic [31:0]      head_data,
    output logic             match
);

    localparam int PW = ptr_width(SQDEPTH);
    localparam logic [PW-1:0] LAST = PW'(SQDEPTH - 1);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(SQDEPTH);

    logic [WIDTH-1:0] addr_mem [SQDEPTH];
    logic [31:0]      data_mem [SQDEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [PW-1:0]    offs;

    assign full      = (count == DEPTH);
    assign empty     = (count == '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= enq_addr;
            data_mem[tail] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= (tail == LAST) ? '0 : tail + 1'b1;
            if (deq) head <= (head == LAST) ? '0 : head + 1'b1;
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        match = 1'b0;
        offs  = '0;
        for (int i = 0; i < SQDEPTH; i++) begin
            offs = PW'(i) - head;
            if (({1'b0, offs} < count) && (addr_mem[i][WIDTH-1:2] == match_word))
                match = 1'b1;
        end
    end

endmodule

// File: rtl/dcache_arbiter.sv
// Single-port data-cache arbiter between MEM-stage loads and committed stores,
// with load-starvation limiting, hazard stalling and a fence/drain mode.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_ARB   | loads first (unless hazarded/flushed/starving), else store
//   ST_DRAIN | loads blocked, stores written back until queue empty
module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TAGW    = ROB_TAGW,
    parameter int SQDEPTH = SQDEPTH_DEF,
    parameter int STARVE  = STARVE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [WIDTH-1:0] i_ld_addr,
    input  logic [TAGW-1:0]  i_ld_tag,
    output logic             o_ld_rvalid,
    output logic [31:0]      o_ld_rdata,
    output logic [TAGW-1:0]  o_ld_rtag,
    input  logic             i_st_valid,
    output logic             o_st_ready,
    input  logic [WIDTH-1:0] i_st_addr,
    input  logic [31:0]      i_st_data,
    input  logic             i_flush,
    input  logic             i_drain,
    output logic             o_drained,
    output logic             o_we,
    output logic [WIDTH-1:0] o_DcacheAddr,
    output logic [31:0]      o_data,
    input  logic [31:0]      i_DcacheData
);

    localparam int SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [SW-1:0]    starve_cnt;
    logic             rvalid_q;
    logic [TAGW-1:0]  tag_q;
    logic             sq_full;
    logic             sq_empty;
    logic             hazard;
    logic             ld_gnt;
    logic             st_gnt;
    logic [WIDTH-1:0] head_addr;
    logic [31:0]      head_data;

    store_fifo #(
        .WIDTH   (WIDTH),
        .SQDEPTH (SQDEPTH)
    ) u_store_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .enq        (i_st_valid & ~sq_full),
        .enq_addr   (i_st_addr),
        .enq_data   (i_st_data),
        .deq        (st_gnt),
        .match_word (i_ld_addr[WIDTH-1:2]),
        .full       (sq_full),
        .empty      (sq_empty),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .match      (hazard)
    );

    // Grants are forced low while reset is held so every output reads idle.
    always_comb begin
        ld_gnt = 1'b0;
        st_gnt = 1'b0;
        if (i_rst_n) begin
            if (state == ST_DRAIN) begin
                st_gnt = ~sq_empty;
            end else begin
                ld_gnt = i_ld_valid & ~hazard & ~i_flush & (starve_cnt < STARVE_MAX);
                st_gnt = ~ld_gnt & ~sq_empty;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:   if (sq_full || i_drain) state_nxt = ST_DRAIN;
            ST_DRAIN: if (sq_empty && !i_drain) state_nxt = ST_ARB;
            default:  state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_ARB;
            starve_cnt <= '0;
            rvalid_q   <= 1'b0;
            tag_q      <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_q <= ld_gnt;
            if (ld_gnt) tag_q <= i_ld_tag;
            if (st_gnt || sq_empty)
                starve_cnt <= '0;
            else if (ld_gnt && (starve_cnt < STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign o_ld_ready   = ld_gnt;
    assign o_st_ready   = ~sq_full;
    assign o_we         = st_gnt;
    assign o_DcacheAddr = st_gnt ? head_addr : (ld_gnt ? i_ld_addr : '0);
    assign o_data       = st_gnt ? head_data : '0;
    assign o_ld_rvalid  = rvalid_q & ~i_flush;
    assign o_ld_rdata   = o_ld_rvalid ? i_DcacheData : '0;
    assign o_ld_rtag    = tag_q;
    // A write completes on its grant edge, so an empty queue means nothing is in flight.
    assign o_drained    = i_rst_n & sq_empty & i_drain;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Bench for dcache_arbiter: directed table, corner-case sequences, then random
// traffic checked cycle by cycle against a queue-based reference model.
module tb_dcache_arbiter;

    localparam int WIDTH   = 12;
    localparam int TAGW    = 6;
    localparam int SQDEPTH = 4;
    localparam int STARVE  = 3;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_ld_valid;
    logic             o_ld_ready;
    logic [WIDTH-1:0] i_ld_addr;
    logic [TAGW-1:0]  i_ld_tag;
    logic             o_ld_rvalid;
    logic [31:0]      o_ld_rdata;
    logic [TAGW-1:0]  o_ld_rtag;
    logic             i_st_valid;
    logic             o_st_ready;
    logic [WIDTH-1:0] i_st_addr;
    logic [31:0]      i_st_data;
    logic             i_flush;
    logic             i_drain;
    logic             o_drained;
    logic             o_we;
    logic [WIDTH-1:0] o_DcacheAddr;
    logic [31:0]      o_data;
    logic [31:0]      i_DcacheData;

    dcache_arbiter #(
        .WIDTH(WIDTH), .TAGW(TAGW), .SQDEPTH(SQDEPTH), .STARVE(STARVE)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_addr(i_ld_addr), .i_ld_tag(i_ld_tag),
        .o_ld_rvalid(o_ld_rvalid), .o_ld_rdata(o_ld_rdata), .o_ld_rtag(o_ld_rtag),
        .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
        .i_st_addr(i_st_addr), .i_st_data(i_st_data),
        .i_flush(i_flush), .i_drain(i_drain), .o_drained(o_drained),
        .o_we(o_we), .o_DcacheAddr(o_DcacheAddr), .o_data(o_data),
        .i_DcacheData(i_DcacheData)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] init_word(input int a);
        if (a == 4) return 32'hDEADBEEF;
        return 32'hA5000000 | 32'(a);
    endfunction

    // Synchronous single-port memory seen by the DUT.
    logic [31:0] mem [1024];
    logic [31:0] rd_q = '0;
    logic        mem_init_done = 1'b0;
    assign i_DcacheData = rd_q;
    always @(posedge i_clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else begin
            if (o_we) mem[o_DcacheAddr[WIDTH-1:2]] <= o_data;
            rd_q <= mem[o_DcacheAddr[WIDTH-1:2]];
        end
    end

    typedef struct packed {
        logic             ld_valid;
        logic [WIDTH-1:0] ld_addr;
        logic [TAGW-1:0]  ld_tag;
        logic             st_valid;
        logic [WIDTH-1:0] st_addr;
        logic [31:0]      st_data;
        logic             flush;
        logic             drain;
    } in_t;

    typedef struct packed {
        logic             ld_ready;
        logic             rvalid;
        logic [31:0]      rdata;
        logic [TAGW-1:0]  rtag;
        logic             we;
        logic [WIDTH-1:0] addr;
        logic [31:0]      data;
        logic             st_ready;
        logic             drained;
    } out_t;

    typedef struct { in_t in; out_t exp; } vec_t;
    typedef struct { logic [WIDTH-1:0] addr; logic [31:0] data; } st_t;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: the store queue as a plain queue plus a few scalars.
    st_t             mq[$];
    logic [31:0]     mm [1024];
    int              m_starve;
    bit              m_drain_mode;
    bit              m_pend;
    logic [TAGW-1:0] m_tag;
    logic [31:0]     m_pdata;

    function automatic in_t mk(bit lv, logic [WIDTH-1:0] la, logic [TAGW-1:0] lt,
                               bit sv, logic [WIDTH-1:0] sa, logic [31:0] sd,
                               bit fl, bit dr);
        in_t x;
        x.ld_valid = lv; x.ld_addr = la; x.ld_tag = lt;
        x.st_valid = sv; x.st_addr = sa; x.st_data = sd;
        x.flush = fl; x.drain = dr;
        return x;
    endfunction

    function automatic out_t ex(bit lr, bit rv, logic [31:0] rd, logic [TAGW-1:0] rt,
                                bit we, logic [WIDTH-1:0] ad, logic [31:0] da,
                                bit sr, bit dn);
        out_t o;
        o.ld_ready = lr; o.rvalid = rv; o.rdata = rd; o.rtag = rt;
        o.we = we; o.addr = ad; o.data = da; o.st_ready = sr; o.drained = dn;
        return o;
    endfunction

    function automatic in_t idle();
        return mk(0, '0, '0, 0, '0, '0, 0, 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_drain_mode = 0;
        m_pend = 0;
        m_tag = '0;
        m_pdata = '0;
    endtask

    task automatic model_eval(input in_t x, output out_t e, output bit lg, output bit sg);
        bit hz;
        hz = 0;
        foreach (mq[k]) if (mq[k].addr[WIDTH-1:2] == x.ld_addr[WIDTH-1:2]) hz = 1;
        lg = 0;
        sg = 0;
        if (m_drain_mode) begin
            sg = (mq.size() != 0);
        end else begin
            lg = x.ld_valid && !hz && !x.flush && (m_starve < STARVE);
            sg = !lg && (mq.size() != 0);
        end
        e = '0;
        e.ld_ready = lg;
        e.we = sg;
        if (sg) begin
            e.addr = mq[0].addr;
            e.data = mq[0].data;
        end else if (lg) begin
            e.addr = x.ld_addr;
        end
        e.rvalid = m_pend && !x.flush;
        if (e.rvalid) e.rdata = m_pdata;
        e.rtag = m_tag;
        e.st_ready = (mq.size() < SQDEPTH);
        e.drained = (mq.size() == 0) && x.drain;
    endtask

    task automatic model_commit(input in_t x, input bit lg, input bit sg);
        bit was_empty;
        bit was_full;
        st_t s;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == SQDEPTH);
        if (sg) begin
            mm[mq[0].addr[WIDTH-1:2]] = mq[0].data;
            void'(mq.pop_front());
        end
        if (sg || was_empty) m_starve = 0;
        else if (lg && m_starve < STARVE) m_starve++;
        m_pend = lg;
        if (lg) begin
            m_tag = x.ld_tag;
            m_pdata = mm[x.ld_addr[WIDTH-1:2]];
        end
        if (!m_drain_mode) begin
            if (was_full || x.drain) m_drain_mode = 1;
        end else if (was_empty && !x.drain) begin
            m_drain_mode = 0;
        end
        if (x.st_valid && !was_full) begin
            s.addr = x.st_addr;
            s.data = x.st_data;
            mq.push_back(s);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string p, input out_t a, input out_t e);
        chk({p, ".ld_ready"}, 32'(a.ld_ready), 32'(e.ld_ready));
        chk({p, ".rvalid"},   32'(a.rvalid),   32'(e.rvalid));
        chk({p, ".rdata"},    a.rdata,         e.rdata);
        chk({p, ".rtag"},     32'(a.rtag),     32'(e.rtag));
        chk({p, ".we"},       32'(a.we),       32'(e.we));
        chk({p, ".addr"},     32'(a.addr),     32'(e.addr));
        chk({p, ".data"},     a.data,          e.data);
        chk({p, ".st_ready"}, 32'(a.st_ready), 32'(e.st_ready));
        chk({p, ".drained"},  32'(a.drained),  32'(e.drained));
    endtask

    function automatic out_t sample();
        return ex(o_ld_ready, o_ld_rvalid, o_ld_rdata, o_ld_rtag, o_we,
                  o_DcacheAddr, o_data, o_st_ready, o_drained);
    endfunction

    task automatic drive(input in_t x);
        i_ld_valid = x.ld_valid; i_ld_addr = x.ld_addr; i_ld_tag = x.ld_tag;
        i_st_valid = x.st_valid; i_st_addr = x.st_addr; i_st_data = x.st_data;
        i_flush = x.flush; i_drain = x.drain;
    endtask

    // Called at posedge+1: drive, compare mid-cycle, advance model, move to next cycle.
    task automatic step(input in_t x, output out_t act);
        out_t e;
        bit lg, sg;
        drive(x);
        #4;
        model_eval(x, e, lg, sg);
        act = sample();
        cmp_all("mdl", act, e);
        model_commit(x, lg, sg);
        @(posedge i_clk);
        #1;
    endtask

    vec_t tbl[9];
    out_t a;
    out_t rst_exp;
    bit   drain_r;

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = init_word(i);
        model_reset();
        rst_exp = ex(0, 0, '0, '0, 0, '0, '0, 1, 0);

        // Single load, hazard against a queued store, flush blocking and killing.
        tbl[0] = '{mk(1, 12'h010, 6'd5, 0, '0, '0, 0, 0), ex(1, 0, '0, 6'd0, 0, 12'h010, '0, 1, 0)};
        tbl[1] = '{idle(),                                 ex(0, 1, 32'hDEADBEEF, 6'd5, 0, '0, '0, 1, 0)};
        tbl[2] = '{mk(0, '0, '0, 1, 12'h020, 32'h11, 0, 0), ex(0, 0, '0, 6'd5, 0, '0, '0, 1, 0)};
        tbl[3] = '{mk(1, 12'h020, 6'd7, 0, '0, '0, 0, 0), ex(0, 0, '0, 6'd5, 1, 12'h020, 32'h11, 1, 0)};
        tbl[4] = '{mk(1, 12'h020, 6'd7, 0, '0, '0, 0, 0), ex(1, 0, '0, 6'd5, 0, 12'h020, '0, 1, 0)};
        tbl[5] = '{idle(),                                 ex(0, 1, 32'h11, 6'd7, 0, '0, '0, 1, 0)};
        tbl[6] = '{mk(1, 12'h030, 6'd9, 0, '0, '0, 1, 0), ex(0, 0, '0, 6'd7, 0, '0, '0, 1, 0)};
        tbl[7] = '{mk(1, 12'h030, 6'd9, 0, '0, '0, 0, 0), ex(1, 0, '0, 6'd7, 0, 12'h030, '0, 1, 0)};
        tbl[8] = '{mk(0, '0, '0, 0, '0, '0, 1, 0),        ex(0, 0, '0, 6'd9, 0, '0, '0, 1, 0)};

        drive(mk(1, 12'h010, 6'd3, 1, 12'h0F0, 32'h1, 0, 1));
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        #4;
        cmp_all("reset", sample(), rst_exp);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].in, a);
            cmp_all($sformatf("tbl%0d", i), a, tbl[i].exp);
        end

        // Flush in the response cycle still lets the queued store through.
        step(mk(1, 12'h044, 6'd3, 1, 12'h040, 32'h22, 0, 0), a);
        chk("flush.grant", 32'(a.ld_ready), 32'd1);
        step(mk(0, '0, '0, 0, '0, '0, 1, 0), a);
        chk("flush.rvalid", 32'(a.rvalid), 32'd0);
        chk("flush.we", 32'(a.we), 32'd1);
        chk("flush.addr", 32'(a.addr), 32'h040);
        step(mk(1, 12'h040, 6'd4, 0, '0, '0, 0, 0), a);
        step(idle(), a);
        chk("flush.readback", a.rdata, 32'h22);

        // Starvation: three load grants, one store, then loads again.
        step(mk(0, '0, '0, 1, 12'h050, 32'h55, 0, 0), a);
        for (int k = 0; k < 5; k++) begin
            step(mk(1, 12'h060, 6'(k), 0, '0, '0, 0, 0), a);
            chk($sformatf("starve.ready%0d", k), 32'(a.ld_ready), (k == 3) ? 32'd0 : 32'd1);
            chk($sformatf("starve.we%0d", k), 32'(a.we), (k == 3) ? 32'd1 : 32'd0);
        end
        step(idle(), a);

        // Fill to full under load pressure, then drain in FIFO order.
        for (int k = 0; k < 10; k++) begin
            step(mk(1, 12'h200, 6'd1, k < 4, 12'(12'h100 + 4 * k), 32'(32'hF0 + k), 0, 0), a);
            if (k == 4) chk("fill.st_ready", 32'(a.st_ready), 32'd0);
            if (k >= 4 && k <= 7) begin
                chk($sformatf("fill.we%0d", k), 32'(a.we), 32'd1);
                chk($sformatf("fill.addr%0d", k), 32'(a.addr), 32'(12'h100 + 4 * (k - 4)));
            end
            if (k >= 5 && k <= 8) chk($sformatf("fill.ld_blk%0d", k), 32'(a.ld_ready), 32'd0);
            if (k == 9) chk("fill.resume", 32'(a.ld_ready), 32'd1);
        end
        step(idle(), a);

        // Fence with two stores queued.
        step(mk(1, 12'h200, 6'd2, 1, 12'h300, 32'h1, 0, 0), a);
        step(mk(1, 12'h200, 6'd2, 1, 12'h304, 32'h2, 0, 0), a);
        for (int k = 0; k < 3; k++) begin
            step(mk(0, '0, '0, 0, '0, '0, 0, 1), a);
            chk($sformatf("fence.drained%0d", k), 32'(a.drained), (k == 2) ? 32'd1 : 32'd0);
            chk($sformatf("fence.we%0d", k), 32'(a.we), (k == 2) ? 32'd0 : 32'd1);
        end
        step(idle(), a);
        step(idle(), a);

        // Reset with three stores queued and a response pending.
        for (int k = 0; k < 3; k++)
            step(mk(1, 12'h200, 6'd2, 1, 12'(12'h400 + 4 * k), 32'(k + 7), 0, 0), a);
        drive(mk(1, 12'h200, 6'd2, 1, 12'h480, 32'h9, 0, 1));
        i_rst_n = 1'b0;
        #4;
        cmp_all("midreset", sample(), rst_exp);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            step(idle(), a);
            chk($sformatf("postrst.we%0d", k), 32'(a.we), 32'd0);
            chk($sformatf("postrst.st_ready%0d", k), 32'(a.st_ready), 32'd1);
        end

        // Random traffic against the model.
        drain_r = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) drain_r = ~drain_r;
            step(mk($urandom_range(0, 1) == 1,
                    12'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                    6'($urandom_range(0, 63)),
                    $urandom_range(0, 2) == 0,
                    12'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                    $urandom(),
                    $urandom_range(0, 7) == 0,
                    drain_r), a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
